// File: rtl/musicbox_pkg.sv
// Shared types and widths for the musicbox record/playback datapath.
// Ports: none (package only).
// Imported by the recording writer and the playback reader.
package musicbox_pkg;

  localparam int SAMPLE_WIDTH     = 16;
  localparam int SDRAM_ADDR_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    PLAY    = 2'd2,
    ABORT   = 2'd3
  } playback_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Purpose: synchronous FIFO for returned samples, with flush, count, full and empty.
// Latency: a pushed word is poppable the next cycle; pop_data shows the head word combinationally.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: clk/rst_n, flush, push/push_data, pop/pop_data, full, empty, count.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty && !flush;
    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; validity is tracked by count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/recording_playback_reader.sv
// Purpose: streams stored samples out of SDRAM (one read outstanding) into a FIFO, releasing one per sample_tick.
// Latency: sample_tick in cycle N gives audio_sampleValid in N+1; a starved tick bumps underrun_count instead.
// Backpressure: read request held until mem_readAck; no new read while one is outstanding or the FIFO has no room.
// Ports: clock_50Mhz/reset_n; start_pulse, stop_pulse, recording_length, sample_tick;
//        mem_readRequest/Address/Ack/DataValid/Data; audio_sample/Valid, busy, done_pulse, underrun_count.
module recording_playback_reader
  import musicbox_pkg::*;
#(
  parameter int ADDR_WIDTH = SDRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock_50Mhz,
  input  logic                  reset_n,
  input  logic                  start_pulse,
  input  logic                  stop_pulse,
  input  logic [ADDR_WIDTH-1:0] recording_length,
  input  logic                  sample_tick,
  output logic                  mem_readRequest,
  output logic [ADDR_WIDTH-1:0] mem_readAddress,
  input  logic                  mem_readAck,
  input  logic                  mem_readDataValid,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic [DATA_WIDTH-1:0] audio_sample,
  output logic                  audio_sampleValid,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [7:0]            underrun_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  playback_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] delivered_q, delivered_d;
  logic                  outstanding_q, outstanding_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [7:0]            underrun_q, underrun_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  acked, rd_ret, issue_ok;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clock_50Mhz),
    .rst_n     (reset_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (mem_readData),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    fetch_addr_d  = fetch_addr_q;
    delivered_d   = delivered_q;
    outstanding_d = outstanding_q;
    req_d         = req_q;
    sample_d      = sample_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    underrun_d    = underrun_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;

    acked  = req_q && mem_readAck;
    // Stray data-valid with nothing outstanding is ignored.
    rd_ret = outstanding_q && mem_readDataValid;
    // Room is reserved for the outstanding read so a full FIFO can never be overrun.
    issue_ok = !req_q && !outstanding_q && (fetch_addr_q < len_q) &&
               ((fifo_count + CW'(outstanding_q)) < CW'(FIFO_DEPTH));

    if (acked) begin
      fetch_addr_d  = fetch_addr_q + ADDR_WIDTH'(1);
      outstanding_d = 1'b1;
    end
    if (rd_ret) outstanding_d = 1'b0;
    // Output returns to silence the cycle after completion is signalled.
    if (done_q) sample_d = '0;

    case (state_q)
      IDLE: begin
        if (start_pulse && !stop_pulse) begin
          if (recording_length != '0) begin
            state_d      = PREFILL;
            len_d        = recording_length;
            fetch_addr_d = '0;
            delivered_d  = '0;
            underrun_d   = '0;
            fifo_flush   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PREFILL, PLAY: begin
        fifo_push = rd_ret;
        req_d     = req_q ? !mem_readAck : issue_ok;
        if (stop_pulse) begin
          req_d = 1'b0;
          // A read accepted this cycle, or one still in flight, must drain before IDLE.
          if (acked || (outstanding_q && !mem_readDataValid)) state_d = ABORT;
          else                                                state_d = IDLE;
        end else if (state_q == PREFILL) begin
          if (fifo_full || (fetch_addr_q == len_q)) state_d = PLAY;
        end else if (delivered_q == len_q) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (sample_tick) begin
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            sample_d    = fifo_rd_data;
            valid_d     = 1'b1;
            delivered_d = delivered_q + ADDR_WIDTH'(1);
          end else if (underrun_q != 8'hFF) begin
            underrun_d = underrun_q + 8'd1;
          end
        end
      end
      ABORT: begin
        if (rd_ret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      fetch_addr_q  <= '0;
      delivered_q   <= '0;
      outstanding_q <= 1'b0;
      req_q         <= 1'b0;
      sample_q      <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      fetch_addr_q  <= fetch_addr_d;
      delivered_q   <= delivered_d;
      outstanding_q <= outstanding_d;
      req_q         <= req_d;
      sample_q      <= sample_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign mem_readRequest   = req_q;
  assign mem_readAddress   = fetch_addr_q;
  assign audio_sample      = sample_q;
  assign audio_sampleValid = valid_q;
  assign busy              = (state_q != IDLE);
  assign done_pulse        = done_q;
  assign underrun_count    = underrun_q;

endmodule

// File: tb/tb_recording_playback_reader.sv
module tb_recording_playback_reader;
  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clock_50Mhz = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_pulse = 1'b0;
  logic          stop_pulse = 1'b0;
  logic [AW-1:0] recording_length = '0;
  logic          sample_tick = 1'b0;
  logic          mem_readRequest;
  logic [AW-1:0] mem_readAddress;
  logic          mem_readAck = 1'b0;
  logic          mem_readDataValid = 1'b0;
  logic [DW-1:0] mem_readData = '0;
  logic [DW-1:0] audio_sample;
  logic          audio_sampleValid;
  logic          busy;
  logic          done_pulse;
  logic [7:0]    underrun_count;

  recording_playback_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock_50Mhz       (clock_50Mhz),
    .reset_n           (reset_n),
    .start_pulse       (start_pulse),
    .stop_pulse        (stop_pulse),
    .recording_length  (recording_length),
    .sample_tick       (sample_tick),
    .mem_readRequest   (mem_readRequest),
    .mem_readAddress   (mem_readAddress),
    .mem_readAck       (mem_readAck),
    .mem_readDataValid (mem_readDataValid),
    .mem_readData      (mem_readData),
    .audio_sample      (audio_sample),
    .audio_sampleValid (audio_sampleValid),
    .busy              (busy),
    .done_pulse        (done_pulse),
    .underrun_count    (underrun_count)
  );

  always #10 clock_50Mhz = ~clock_50Mhz;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Stored recording contents as a pure function of address.
  int data_mode = 0;
  function automatic logic [15:0] mem_f(input logic [23:0] a);
    if (data_mode == 0) return 16'(a * 3);
    return 16'((a * 40503) ^ 32'h5A3C);
  endfunction

  // SDRAM read-port responder: ack after ack_delay cycles, data lat cycles after ack.
  int          ack_delay = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          pend_cnt = 0;
  logic        pend = 1'b0;
  logic [23:0] ack_addr = '0;
  logic [23:0] pend_addr = '0;
  always @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      mem_readAck = 1'b0;
      mem_readDataValid = 1'b0;
      pend = 1'b0;
      wait_cnt = 0;
    end else begin
      #1;
      if (mem_readAck) begin
        pend = 1'b1;
        pend_cnt = lat;
        pend_addr = ack_addr;
      end
      mem_readAck = 1'b0;
      mem_readDataValid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_readDataValid = 1'b1;
          mem_readData = mem_f(pend_addr);
          pend = 1'b0;
        end
      end
      if (mem_readRequest) begin
        if (wait_cnt >= ack_delay) begin
          mem_readAck = 1'b1;
          ack_addr = mem_readAddress;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  int tick_period = 0;
  int tick_cnt = 0;
  always @(posedge clock_50Mhz) begin
    #1;
    sample_tick = 1'b0;
    if (tick_period > 0) begin
      tick_cnt++;
      if (tick_cnt >= tick_period) begin
        tick_cnt = 0;
        sample_tick = 1'b1;
      end
    end
  end

  // Reference model in counts: A reads accepted, R samples returned, D samples delivered.
  logic        m_active = 1'b0, m_play = 1'b0;
  int          A = 0, R = 0, D = 0, ur = 0, m_len = 0, m_out = 0;
  logic        exp_valid = 1'b0, exp_starved = 1'b0, exp_done = 1'b0, exp_clear = 1'b0;
  logic [15:0] exp_data = '0, last_val = '0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_stop = 1'b0;
  logic [23:0] prev_addr = '0, first_addr = '0;
  int          proto_viol = 0, req_cycles = 0, done_seen = 0;

  always @(negedge clock_50Mhz) begin
    logic nv, ns, nd;
    if (!reset_n) begin
      m_active = 1'b0; m_play = 1'b0; m_out = 0;
      exp_valid = 1'b0; exp_starved = 1'b0; exp_done = 1'b0; exp_clear = 1'b0;
      last_val = '0; prev_req = 1'b0; prev_ack = 1'b0;
    end else begin
      if (exp_valid || audio_sampleValid) begin
        check_eq("valid", audio_sampleValid, exp_valid);
        if (exp_valid) check_eq("sample", audio_sample, exp_data);
      end
      if (exp_starved) check_eq("hold", audio_sample, last_val);
      if (exp_done || done_pulse) check_eq("done", done_pulse, exp_done);
      if (exp_clear) check_eq("clear", audio_sample, 0);
      if (exp_valid) last_val = exp_data;
      if (exp_done) last_val = '0;
      done_seen += int'(done_pulse);
      if (mem_readRequest) req_cycles++;
      if (prev_req && !prev_ack && !prev_stop &&
          (!mem_readRequest || mem_readAddress != prev_addr)) proto_viol++;
      if (R - D > DEPTH) proto_viol++;

      nv = 1'b0; ns = 1'b0; nd = 1'b0;
      exp_clear = exp_done;
      if (stop_pulse) begin
        m_active = 1'b0;
      end else if (start_pulse && !busy) begin
        if (recording_length != 0) begin
          m_active = 1'b1; m_play = 1'b0;
          A = 0; R = 0; D = 0; ur = 0; m_len = int'(recording_length);
        end else begin
          nd = 1'b1;
        end
      end else if (m_active) begin
        if (m_play && D == m_len) begin
          nd = 1'b1;
          m_active = 1'b0;
        end else if (m_play && sample_tick) begin
          if (R > D) begin
            nv = 1'b1;
            exp_data = mem_f(24'(D));
            D++;
          end else begin
            ns = 1'b1;
            if (ur < 255) ur++;
          end
        end
        if (!m_play && (R >= DEPTH || A >= m_len)) m_play = 1'b1;
      end
      if (mem_readRequest && mem_readAck) begin
        if (A == 0) first_addr = mem_readAddress;
        A++;
        m_out++;
      end
      if (mem_readDataValid && m_out > 0) begin
        if (m_active) R++;
        m_out--;
      end
      if (m_out > 1) proto_viol++;
      exp_valid = nv; exp_starved = ns; exp_done = nd;
      prev_req = mem_readRequest; prev_ack = mem_readAck;
      prev_addr = mem_readAddress; prev_stop = stop_pulse;
    end
  end

  task automatic step();
    @(posedge clock_50Mhz);
    #1;
  endtask

  task automatic do_start(input int len);
    step();
    recording_length = AW'(len);
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || m_active) && n < budget) begin
      @(negedge clock_50Mhz);
      n++;
    end
    if (n >= budget) check_eq(tag, busy, 0);
  endtask

  task automatic run_play(input string tag, input int len, input int ackd, input int latency,
                          input int period, input int mode);
    int d0;
    d0 = done_seen;
    data_mode = mode; ack_delay = ackd; lat = latency; tick_period = period;
    proto_viol = 0;
    do_start(len);
    wait_idle({tag, "_timeout"}, len * (period + ackd + latency + 8) + 400);
    repeat (4) step();
    tick_period = 0;
    check_eq({tag, "_underrun"}, underrun_count, ur);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done_once"}, done_seen - d0, 1);
    check_eq({tag, "_delivered"}, D, len);
    check_eq({tag, "_proto"}, proto_viol, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, n;
    #25;
    check_eq("rst_sample", audio_sample, 0);
    check_eq("rst_valid", audio_sampleValid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req", mem_readRequest, 0);
    check_eq("rst_addr", mem_readAddress, 0);
    check_eq("rst_done", done_pulse, 0);
    check_eq("rst_underrun", underrun_count, 0);
    step();
    reset_n = 1'b1;
    repeat (2) step();

    run_play("basic", 5, 0, 1, 20, 0);
    run_play("slow_ack", 20, 4, 2, 5, 1);
    run_play("starve", 4, 0, 60, 10, 0);

    // Abort with a read in flight.
    data_mode = 0; ack_delay = 0; lat = 30; tick_period = 0;
    d0 = done_seen;
    do_start(10);
    n = 0;
    while (!pend && n < 50) begin @(negedge clock_50Mhz); n++; end
    check_eq("abort_pend", pend, 1);
    step();
    stop_pulse = 1'b1;
    step();
    stop_pulse = 1'b0;
    @(negedge clock_50Mhz);
    check_eq("abort_busy", busy, 1);
    n = 0;
    while (!mem_readDataValid && n < 60) begin @(negedge clock_50Mhz); n++; end
    check_eq("abort_hold", busy, 1);
    @(negedge clock_50Mhz);
    check_eq("abort_exit", busy, 0);
    repeat (3) step();
    check_eq("abort_nodone", done_seen - d0, 0);
    run_play("restart", 3, 0, 1, 5, 0);
    check_eq("restart_addr", first_addr, 0);

    // Zero-length start, then simultaneous start/stop.
    d0 = done_seen; r0 = req_cycles;
    do_start(0);
    repeat (3) step();
    check_eq("len0_done", done_seen - d0, 1);
    check_eq("len0_noreq", req_cycles - r0, 0);
    check_eq("len0_busy", busy, 0);
    d0 = done_seen;
    step();
    recording_length = AW'(5); start_pulse = 1'b1; stop_pulse = 1'b1;
    step();
    start_pulse = 1'b0; stop_pulse = 1'b0;
    repeat (3) step();
    check_eq("startstop_busy", busy, 0);
    check_eq("startstop_nodone", done_seen - d0, 0);
    check_eq("startstop_noreq", req_cycles - r0, 0);

    // Asynchronous reset in the middle of playback.
    data_mode = 1; ack_delay = 0; lat = 2; tick_period = 4;
    do_start(10);
    n = 0;
    while (D < 3 && n < 400) begin @(negedge clock_50Mhz); n++; end
    check_eq("mid_play_reached", D >= 3, 1);
    @(posedge clock_50Mhz);
    #3;
    reset_n = 1'b0;
    tick_period = 0;
    #1;
    check_eq("arst_sample", audio_sample, 0);
    check_eq("arst_valid", audio_sampleValid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_req", mem_readRequest, 0);
    check_eq("arst_done", done_pulse, 0);
    check_eq("arst_underrun", underrun_count, 0);
    repeat (2) @(posedge clock_50Mhz);
    #1;
    reset_n = 1'b1;
    run_play("post_reset", 3, 0, 1, 6, 0);
    check_eq("post_reset_addr", first_addr, 0);

    for (int i = 0; i < 4; i++) begin
      run_play("rand", int'($urandom_range(12, 1)), int'($urandom_range(3, 0)),
               int'($urandom_range(8, 1)), int'($urandom_range(15, 3)), int'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/recording_playback_reader.md
Name: recording_playback_reader

Overview:
- Read side of the recording path: when PlayRecording is triggered, streams stored 16-bit audio samples back out of SDRAM.
- Issues single-outstanding read requests to the SDRAM controller's read port and buffers the returned samples in a small FIFO.
- Releases one sample per audio sample tick toward the audio output stage.
- Mirrors the recording writer: same address space, same sample width, address 0 = first sample.

Parameters:
ADDR_WIDTH, 24, sample address width (word addressing, one 16-bit sample per address)
DATA_WIDTH, 16, sample width
FIFO_DEPTH, 8, buffered samples; power of two, >= 2

Ports:
clock_50Mhz  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_pulse  in  1  one-cycle start (from state controller on PlayRecording)
stop_pulse  in  1  one-cycle abort
recording_length  in  ADDR_WIDTH  number of stored samples; latched on accepted start
sample_tick  in  1  one-cycle strobe at audio sample rate
mem_readRequest  out  1  read request to SDRAM controller
mem_readAddress  out  ADDR_WIDTH  sample address, valid while mem_readRequest=1
mem_readAck  in  1  request accepted this cycle
mem_readDataValid  in  1  mem_readData valid this cycle
mem_readData  in  DATA_WIDTH  returned sample
audio_sample  out  DATA_WIDTH  current output sample (two's complement)
audio_sampleValid  out  1  one-cycle pulse when audio_sample updates
busy  out  1  high in any state except IDLE
done_pulse  out  1  one-cycle pulse on normal completion
underrun_count  out  8  saturating count of starved ticks in current playback

Behaviour:
- Clock and reset: single clock clock_50Mhz; reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, all outputs 0, FIFO empty, address/counters 0.

State machine (IDLE, PREFILL, PLAY, ABORT):
- IDLE:
  - start_pulse with recording_length!=0: latch length, fetch address=0, delivered=0, underrun_count=0, flush FIFO; next state PREFILL.
  - start_pulse with length==0: done_pulse next cycle, stay IDLE.
  - start_pulse and stop_pulse together: stop wins, start ignored.
- PREFILL: fetch engine runs; sample_tick ignored (no output, no underrun). Go to PLAY when FIFO full or fetch address==length.
- PLAY:
  - On sample_tick with FIFO non-empty: pop; next cycle audio_sample=popped data and audio_sampleValid=1; delivered+1.
  - On sample_tick with FIFO empty: audio_sample holds, no valid pulse, underrun_count+1 saturating at 255.
  - When delivered reaches length: done_pulse for 1 cycle, audio_sample cleared to 0 the following cycle, state IDLE.
- stop_pulse in PREFILL or PLAY:
  - No read outstanding: go to IDLE immediately, no done_pulse.
  - Read outstanding: go to ABORT; wait for its mem_readDataValid, discard the data, then IDLE. No done_pulse.
- start_pulse while busy: ignored.

Fetch engine:
- At most one read outstanding.
- Issues a request when fetch address<length and FIFO count + outstanding < FIFO_DEPTH.
- mem_readRequest and mem_readAddress held stable until the cycle mem_readAck=1. Address increments on ack; request drops the next cycle unless a new request is issued.
- mem_readDataValid arrives >=1 cycle after ack; data is pushed to the FIFO that cycle.
- mem_readDataValid with no read outstanding: ignored.
- FIFO push and pop in the same cycle: count unchanged, data order preserved. FIFO never overflows by construction.
- Latency: sample_tick at cycle N -> audio_sampleValid at N+1.
- Widths: all address/count comparisons unsigned at ADDR_WIDTH; length 2^ADDR_WIDTH-1 must complete without wrap.
- Reset mid-operation: request deasserts asynchronously; the SDRAM controller discards any in-flight read on reset.

Decomposition:
- musicbox_pkg holds:
  - playback_state_t enum (IDLE, PREFILL, PLAY, ABORT)
  - SAMPLE_WIDTH=16 and SDRAM_ADDR_WIDTH=24, shared with the recording writer
- One sub-module: sample_fifo — synchronous FIFO with push/pop/full/empty/count and flush, parameterised by depth and width.

Test Plan:
- Length 5, memory returns data=addr*3 one cycle after ack, ticks every 20 cycles -> outputs 0,3,6,9,12 in order, each valid exactly 1 cycle after its tick; done_pulse once; busy low afterwards; underrun_count=0.
- Length 20, FIFO_DEPTH=8, ack held off 4 cycles per request -> mem_readAddress stable until ack, never more than 1 read outstanding, FIFO count never exceeds 8.
- Memory latency 60 cycles, ticks every 10 cycles, length 4 -> underrun_count increments on starved ticks, audio_sample holds previous value, all 4 samples still delivered, done_pulse once.
- stop_pulse while a read is outstanding -> state ABORT; returned data not output; IDLE after the data-valid cycle; no done_pulse; next start restarts at address 0.
- start_pulse with length 0 -> done_pulse next cycle, no mem_readRequest; start_pulse and stop_pulse together in IDLE -> nothing happens.
- Assert reset_n low mid-PLAY -> all outputs 0 asynchronously; after release, a new start with length 3 plays samples at addresses 0..2.
